// File: rtl/axi_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB4 bridge.
package axi_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WRESP,
    RRESP
  } bridge_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of the completer index field; never narrower than one bit.
  function automatic int sel_width(input int num_slaves);
    int w;
    w = $clog2(num_slaves);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axi_apb_rw_arbiter.sv
// Two-request round-robin arbiter: on a tie the direction not served last wins.
module axi_apb_rw_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic       accept,
  output logic [1:0] grant
);

  // Set when the most recently accepted grant was a write; reset means "read".
  logic last_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      last_wr <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (req_wr && req_rd) begin
      grant = last_wr ? 2'b01 : 2'b10;
    end else if (req_wr) begin
      grant = 2'b10;
    end else if (req_rd) begin
      grant = 2'b01;
    end
  end

endmodule

// File: rtl/axi_lite_2_apb_mux.sv
// AXI4-Lite slave to APB4 master bridge fanning out to NUM_SLAVES decoded completers.
// Define AXI_APB_TIMEOUT_EN to abort an ACCESS phase with SLVERR after TIMEOUT_CYCLES.
module axi_lite_2_apb_mux
  import axi_apb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_ADDR_BITS  = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [AXI_ADDR_WIDTH-1:0]            PADDR,
  output logic [2:0]                           PPROT,
  output logic [NUM_SLAVES-1:0]                PSEL,
  output logic                                 PENABLE,
  output logic                                 PWRITE,
  output logic [AXI_DATA_WIDTH-1:0]            PWDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES-1:0]                PREADY,
  input  logic [NUM_SLAVES*AXI_DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]                PSLVERR
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam int DW    = AXI_DATA_WIDTH;

  bridge_state_t    state, state_next;
  logic             hs_en;
  logic [1:0]       grant;
  logic             wr_grant, rd_grant;
  logic [SEL_W-1:0] aw_idx, ar_idx, idx;
  logic             aw_mapped, ar_mapped;
  logic             sel_ready, sel_err, timeout;
  logic [DW-1:0]    sel_rdata;

  assign aw_idx    = S_AXI_AWADDR[SLV_ADDR_BITS +: SEL_W];
  assign ar_idx    = S_AXI_ARADDR[SLV_ADDR_BITS +: SEL_W];
  assign aw_mapped = (int'(aw_idx) < NUM_SLAVES);
  assign ar_mapped = (int'(ar_idx) < NUM_SLAVES);

  // Readies are combinational so a grant costs no extra cycle; they stay low in reset.
  assign hs_en = (state == IDLE) && S_AXI_ARESETN;

  axi_apb_rw_arbiter u_arbiter (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .req_wr (hs_en && S_AXI_AWVALID && S_AXI_WVALID),
    .req_rd (hs_en && S_AXI_ARVALID),
    .accept (hs_en),
    .grant  (grant)
  );

  assign wr_grant      = grant[1];
  assign rd_grant      = grant[0];
  assign S_AXI_AWREADY = wr_grant;
  assign S_AXI_WREADY  = wr_grant;
  assign S_AXI_ARREADY = rd_grant;

  assign PENABLE      = (state == ACCESS);
  assign S_AXI_BVALID = (state == WRESP);
  assign S_AXI_RVALID = (state == RRESP);

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    PSEL      = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SEL_W'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DW +: DW];
        PSEL[i]   = (state == SETUP) || (state == ACCESS);
      end
    end
  end

`ifdef AXI_APB_TIMEOUT_EN
  logic [7:0] tcount;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tcount <= '0;
    end else if (state == SETUP) begin
      tcount <= '0;
    end else if ((state == ACCESS) && (tcount != 8'hFF)) begin
      tcount <= tcount + 8'd1;
    end
  end

  // tcount lags the ACCESS cycle number by one, so compare against the limit minus one.
  assign timeout = (state == ACCESS) && !sel_ready && (tcount >= 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (wr_grant) begin
          state_next = aw_mapped ? SETUP : WRESP;
        end else if (rd_grant) begin
          state_next = ar_mapped ? SETUP : RRESP;
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (sel_ready || timeout) begin
          state_next = PWRITE ? WRESP : RRESP;
        end
      end
      WRESP:  if (S_AXI_BREADY) state_next = IDLE;
      RRESP:  if (S_AXI_RREADY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture at grant; response capture when the ACCESS phase ends.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      PADDR       <= '0;
      PPROT       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      idx         <= '0;
      S_AXI_BRESP <= RESP_OKAY;
      S_AXI_RRESP <= RESP_OKAY;
      S_AXI_RDATA <= '0;
    end else if (wr_grant) begin
      PADDR  <= S_AXI_AWADDR;
      PPROT  <= S_AXI_AWPROT;
      PWRITE <= 1'b1;
      PWDATA <= S_AXI_WDATA;
      PSTRB  <= S_AXI_WSTRB;
      idx    <= aw_idx;
      if (!aw_mapped) S_AXI_BRESP <= RESP_DECERR;
    end else if (rd_grant) begin
      PADDR  <= S_AXI_ARADDR;
      PPROT  <= S_AXI_ARPROT;
      PWRITE <= 1'b0;
      PSTRB  <= '0;
      idx    <= ar_idx;
      if (!ar_mapped) begin
        S_AXI_RRESP <= RESP_DECERR;
        S_AXI_RDATA <= '0;
      end
    end else if ((state == ACCESS) && sel_ready) begin
      if (PWRITE) begin
        S_AXI_BRESP <= sel_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        S_AXI_RRESP <= sel_err ? RESP_SLVERR : RESP_OKAY;
        S_AXI_RDATA <= sel_rdata;
      end
    end else if (timeout) begin
      if (PWRITE) begin
        S_AXI_BRESP <= RESP_SLVERR;
      end else begin
        S_AXI_RRESP <= RESP_SLVERR;
        S_AXI_RDATA <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_2_apb_mux.sv
// Self-checking bench for axi_lite_2_apb_mux with three completers (idx 3 is unmapped).
// When AXI_APB_TIMEOUT_EN is defined an extra hung-completer step runs with TIMEOUT_CYCLES=8.
module tb_axi_lite_2_apb_mux;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic resetn;
  logic [AW-1:0] awaddr, araddr, paddr;
  logic [2:0] awprot, arprot, pprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata, pwdata;
  logic [DW/8-1:0] wstrb, pstrb;
  logic [1:0] bresp, rresp;
  logic [NS-1:0] psel, pready, pslverr;
  logic penable, pwrite;
  logic [NS*DW-1:0] prdata;

  int compared = 0;
  int mismatched = 0;
  // Reference model state: 1 when the last served transfer was a write (reset = read).
  bit last_wr;

  always #5 clk = ~clk;

  axi_lite_2_apb_mux #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .NUM_SLAVES     (NS),
    .SLV_ADDR_BITS  (12),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (resetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .PADDR         (paddr),
    .PPROT         (pprot),
    .PSEL          (psel),
    .PENABLE       (penable),
    .PWRITE        (pwrite),
    .PWDATA        (pwdata),
    .PSTRB         (pstrb),
    .PREADY        (pready),
    .PRDATA        (prdata),
    .PSLVERR       (pslverr)
  );

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
                 paddr, pprot, psel, penable, pwrite, pwdata, pstrb});
  endfunction

  // Completer index is the 2-bit field at byte-address bit 12.
  function automatic int slave_of(input logic [AW-1:0] addr);
    return (int'(addr) / 4096) % 4;
  endfunction

  task automatic apply_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, input logic [2:0] p);
    awaddr = a; wdata = d; wstrb = s; awprot = p;
    awvalid = 1'b1; wvalid = 1'b1;
  endtask

  task automatic apply_read(input logic [AW-1:0] a, input logic [2:0] p);
    araddr = a; arprot = p; arvalid = 1'b1;
  endtask

  // Runs one granted transfer from the IDLE negedge to the response handshake.
  task automatic serve(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [3:0] strb, input logic [2:0] prot, input int waits,
                       input bit err, input logic [DW-1:0] rd_word, input int resp_delay);
    int slv;
    bit mapped;
    logic [NS-1:0] oh;
    logic [1:0] exp_resp;
    slv = slave_of(addr);
    mapped = (slv < NS);
    oh = '0;
    if (mapped) oh[slv] = 1'b1;
    exp_resp = err ? 2'b10 : 2'b00;
    #1;
    check_output(is_wr ? "grant_write" : "grant_read", 128'({awready, wready, arready}),
                 is_wr ? 128'(3'b110) : 128'(3'b001));
    @(negedge clk);
    if (is_wr) begin awvalid = 1'b0; wvalid = 1'b0; end
    else arvalid = 1'b0;
    pready = '1;
    pslverr = '1;
    for (int i = 0; i < NS; i++) prdata[i*DW +: DW] = $urandom;
    if (!mapped) begin
      if (is_wr) check_output("decerr_b", 128'({bvalid, bresp, psel}), 128'({1'b1, 2'b11, 3'b000}));
      else check_output("decerr_r", 128'({rvalid, rresp, rdata, psel}),
                        128'({1'b1, 2'b11, 32'h0, 3'b000}));
    end else begin
      pready[slv] = 1'b0;
      pslverr[slv] = err;
      prdata[slv*DW +: DW] = rd_word;
      check_output("setup", 128'({psel, penable, paddr, pwrite, pprot}),
                   128'({oh, 1'b0, addr, is_wr, prot}));
      if (is_wr) check_output("setup_wdata", 128'({pwdata, pstrb}), 128'({wd, strb}));
      else check_output("setup_rstrb", 128'(pstrb), 128'(0));
      for (int k = 0; k <= waits; k++) begin
        @(negedge clk);
        check_output("access", 128'({psel, penable, paddr, pwrite, bvalid, rvalid}),
                     128'({oh, 1'b1, addr, is_wr, 2'b00}));
        pready[slv] = (k == waits);
      end
      @(negedge clk);
      pready = '0;
      if (is_wr) check_output("bresp", 128'({bvalid, bresp, psel, penable}),
                              128'({1'b1, exp_resp, 3'b000, 1'b0}));
      else check_output("rresp", 128'({rvalid, rresp, rdata, psel, penable}),
                        128'({1'b1, exp_resp, rd_word, 3'b000, 1'b0}));
    end
    pready = '0;
    for (int d = 0; d < resp_delay; d++) begin
      @(negedge clk);
      check_output("resp_hold", 128'(is_wr ? bvalid : rvalid), 128'(1));
    end
    if (is_wr) bready = 1'b1; else rready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    rready = 1'b0;
    check_output("resp_done", 128'({bvalid, rvalid}), 128'(0));
    last_wr = is_wr;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rd;
    logic [3:0] ws;
    logic [2:0] wp, rp;
    int mode;
    bit seen;
    int cnt;

    resetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    pready = '0; pslverr = '0; prdata = '0;
    last_wr = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_outputs", all_outs(), 128'(0));
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    check_output("reset_readies", 128'({awready, wready, arready}), 128'(0));
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Directed steps.
    apply_write(16'h1004, 32'hDEADBEEF, 4'hF, 3'b010);
    serve(1'b1, 16'h1004, 32'hDEADBEEF, 4'hF, 3'b010, 0, 1'b0, '0, 0);
    apply_read(16'h2010, 3'b001);
    serve(1'b0, 16'h2010, '0, '0, 3'b001, 3, 1'b0, 32'h12345678, 0);
    apply_read(16'h3000, 3'b000);
    serve(1'b0, 16'h3000, '0, '0, 3'b000, 0, 1'b0, '0, 1);
    apply_write(16'h7ABC, 32'h0BAD0BAD, 4'h1, 3'b000);
    serve(1'b1, 16'h7ABC, 32'h0BAD0BAD, 4'h1, 3'b000, 0, 1'b0, '0, 0);
    apply_read(16'h4000, 3'b100);
    serve(1'b0, 16'h4000, '0, '0, 3'b100, 1, 1'b1, 32'hCAFEF00D, 0);
    apply_write(16'h0008, 32'h11223344, 4'hC, 3'b000);
    serve(1'b1, 16'h0008, 32'h11223344, 4'hC, 3'b000, 2, 1'b0, '0, 2);
    // Both directions pending after a write: read wins, then the write (with PSLVERR).
    apply_write(16'h2020, 32'h55AA55AA, 4'hF, 3'b000);
    apply_read(16'h1010, 3'b000);
    check_output("tie_model_last_write", 128'(last_wr), 128'(1));
    serve(1'b0, 16'h1010, '0, '0, 3'b000, 0, 1'b0, 32'h87654321, 0);
    serve(1'b1, 16'h2020, 32'h55AA55AA, 4'hF, 3'b000, 0, 1'b1, '0, 0);

    // Randomized transfers against the model.
    for (int n = 0; n < 30; n++) begin
      wa = AW'($urandom); ra = AW'($urandom);
      wd = $urandom; rd = $urandom;
      ws = 4'($urandom); wp = 3'($urandom); rp = 3'($urandom);
      mode = $urandom_range(0, 2);
      if (mode != 1) apply_write(wa, wd, ws, wp);
      if (mode != 0) apply_read(ra, rp);
      if (mode == 0) begin
        serve(1'b1, wa, wd, ws, wp, $urandom_range(0, 3), 1'($urandom), '0, $urandom_range(0, 2));
      end else if (mode == 1) begin
        serve(1'b0, ra, '0, '0, rp, $urandom_range(0, 3), 1'($urandom), rd, $urandom_range(0, 2));
      end else if (!last_wr) begin
        serve(1'b1, wa, wd, ws, wp, $urandom_range(0, 3), 1'($urandom), '0, $urandom_range(0, 2));
        serve(1'b0, ra, '0, '0, rp, $urandom_range(0, 3), 1'($urandom), rd, $urandom_range(0, 2));
      end else begin
        serve(1'b0, ra, '0, '0, rp, $urandom_range(0, 3), 1'($urandom), rd, $urandom_range(0, 2));
        serve(1'b1, wa, wd, ws, wp, $urandom_range(0, 3), 1'($urandom), '0, $urandom_range(0, 2));
      end
    end

    // Reset asserted during ACCESS aborts the write without a response.
    apply_write(16'h1000, 32'hA5A50001, 4'h3, 3'b000);
    #1;
    check_output("abort_grant", 128'(awready), 128'(1));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; pready = '0;
    @(negedge clk);
    check_output("abort_in_access", 128'({psel, penable}), 128'({3'b010, 1'b1}));
    resetn = 1'b0;
    #1;
    check_output("abort_outputs_zero", all_outs(), 128'(0));
    @(negedge clk);
    resetn = 1'b1;
    last_wr = 1'b0;
    pready = '1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bvalid | rvalid | penable | (|psel);
    end
    check_output("abort_no_response", 128'(seen), 128'(0));
    pready = '0;

    // After reset the tie goes to write again.
    apply_write(16'h2004, 32'h600DF00D, 4'hF, 3'b000);
    apply_read(16'h0004, 3'b000);
    serve(1'b1, 16'h2004, 32'h600DF00D, 4'hF, 3'b000, 0, 1'b0, '0, 0);
    serve(1'b0, 16'h0004, '0, '0, 3'b000, 0, 1'b0, 32'h0F0F0F0F, 0);

`ifdef AXI_APB_TIMEOUT_EN
    apply_read(16'h1000, 3'b000);
    pready = '0;
    prdata = '1;
    #1;
    check_output("timeout_grant", 128'(arready), 128'(1));
    @(negedge clk);
    arvalid = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (penable && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check_output("timeout_cycles", 128'(cnt), 128'(8));
    check_output("timeout_resp", 128'({rvalid, rresp, rdata, psel}),
                 128'({1'b1, 2'b10, 32'h0, 3'b000}));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    last_wr = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
